fifo_burst_framer: RTL

Downstream consumer of the first-word-fall-through FIFO. It drains the FIFO's read port (`dout`/`empty`/`rd_en`/`cnt`) and emits bounded bursts on a valid/ready stream with a last-beat flag and a per-burst length.
- A burst starts when `BURST_LEN` words are buffered, or when the FIFO has been non-empty for `TIMEOUT` cycles without reaching that level.
- This lets a downstream DMA/packet engine work in whole bursts.

---
 rtl/fifo_burst_framer_if.sv | 27 ++
 rtl/fifo_burst_framer.sv | 107 ++++++++++
 2 files changed

// File: rtl/fifo_burst_framer_if.sv
// rtl/fifo_burst_framer_if.sv - FWFT FIFO read port plus framed output stream
interface fifo_burst_framer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 5
);
  logic [DATA_WIDTH-1:0]  fifo_dout;
  logic                   fifo_empty;
  logic [DEPTH_WIDTH-1:0] fifo_cnt;
  logic                   fifo_rd_en;
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   m_valid;
  logic                   m_last;
  logic [DEPTH_WIDTH-1:0] m_len;
  logic                   m_ready;

  // framer side: consumes the FIFO, produces the stream
  modport master (
    input  fifo_dout, fifo_empty, fifo_cnt, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last, m_len
  );

  // environment side: FIFO read port and stream sink
  modport slave (
    output fifo_dout, fifo_empty, fifo_cnt, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last, m_len
  );
endinterface

// File: rtl/fifo_burst_framer.sv
// rtl/fifo_burst_framer.sv - drains a FWFT FIFO into bounded, length-tagged bursts
module fifo_burst_framer #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 5,
  parameter int BURST_LEN   = 16,
  parameter int TIMEOUT     = 64,
  parameter int TO_WIDTH    = 16
) (
  input  logic                clk,
  input  logic                rst,
  fifo_burst_framer_if.master bus,
  output logic                busy
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  localparam logic [DEPTH_WIDTH-1:0] LP_BURST_LEN = DEPTH_WIDTH'(BURST_LEN);
  localparam logic [TO_WIDTH-1:0]    LP_TIMEOUT   = TO_WIDTH'(TIMEOUT);
  localparam bit                     LP_TO_EN     = (TIMEOUT != 0);

  state_t                 r_state;
  logic [DEPTH_WIDTH-1:0] r_len;
  logic [DEPTH_WIDTH-1:0] r_beat;
  logic [TO_WIDTH-1:0]    r_timer;
  logic [DATA_WIDTH-1:0]  r_m_data;
  logic                   r_m_valid;
  logic                   r_m_last;
  logic [DEPTH_WIDTH-1:0] r_m_len;

  logic w_cnt_start;
  logic w_to_start;
  logic w_rd_en;
  logic w_last_rd;

  // A full burst's worth buffered always wins over the flush timer.
  assign w_cnt_start = (r_state == S_IDLE) && (bus.fifo_cnt >= LP_BURST_LEN);
  assign w_to_start  = (r_state == S_IDLE) && LP_TO_EN && !bus.fifo_empty &&
                       (r_timer == LP_TIMEOUT);

  // Pop only when the output register is free or being drained this cycle;
  // gated by rst so nothing is popped while the burst is being abandoned.
  assign w_rd_en   = !rst && (r_state == S_BURST) && !bus.fifo_empty &&
                     (!r_m_valid || bus.m_ready);
  assign w_last_rd = w_rd_en && (r_beat == r_len - DEPTH_WIDTH'(1));

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_data     = r_m_data;
  assign bus.m_valid    = r_m_valid;
  assign bus.m_last     = r_m_last;
  assign bus.m_len      = r_m_len;
  assign busy           = (r_state == S_BURST) || r_m_valid;

  // Burst FSM, flush timer, beat counter and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_beat    <= '0;
      r_timer   <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_len   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cnt_start) begin
            r_len   <= LP_BURST_LEN;
            r_beat  <= '0;
            r_timer <= '0;
            r_state <= S_BURST;
          end else if (w_to_start) begin
            // fifo_cnt is below BURST_LEN and non-zero here, so len stays legal
            r_len   <= bus.fifo_cnt;
            r_beat  <= '0;
            r_timer <= '0;
            r_state <= S_BURST;
          end else if (bus.fifo_empty) begin
            r_timer <= '0;
          end else if (r_timer < LP_TIMEOUT) begin
            r_timer <= r_timer + TO_WIDTH'(1);
          end
        end
        S_BURST: begin
          if (w_rd_en) begin
            r_beat <= r_beat + DEPTH_WIDTH'(1);
            if (w_last_rd) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_rd_en) begin
        r_m_data  <= bus.fifo_dout;
        r_m_valid <= 1'b1;
        r_m_last  <= w_last_rd;
        r_m_len   <= r_len;
      end else if (bus.m_ready) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

endmodule
